// File: rtl/record_packer.sv
// record_packer: qualifies TDC hits, stamps them with a coarse count, queues them and streams each as a header byte plus little-endian payload bytes
// Ports: clk_i, reset_i (sync, active-high); detect_i, polarity_i, raw_i, fp_i per-channel TDC data (channel 0 in LSBs);
//   chan_en_i channel mask; edge_sel_i 00 both / 01 rising / 10 falling / 11 none;
//   omux_req_o, omux_sel_i, omux_data_o byte handshake; lost_count_o saturating drop count; fifo_level_o FIFO occupancy
module record_packer #(
   parameter int CHANNEL_COUNT = 2,
   parameter int RAW_COUNT     = 9,
   parameter int FP_COUNT      = 13,
   parameter int COARSE_W      = 32,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [CHANNEL_COUNT-1:0]           detect_i,
   input  logic [CHANNEL_COUNT-1:0]           polarity_i,
   input  logic [CHANNEL_COUNT*RAW_COUNT-1:0] raw_i,
   input  logic [CHANNEL_COUNT*FP_COUNT-1:0]  fp_i,
   input  logic [CHANNEL_COUNT-1:0]           chan_en_i,
   input  logic [1:0]                         edge_sel_i,
   output logic                               omux_req_o,
   input  logic                               omux_sel_i,
   output logic [7:0]                         omux_data_o,
   output logic [15:0]                        lost_count_o,
   output logic [$clog2(FIFO_DEPTH):0]        fifo_level_o
);
   localparam int REC_W  = 2*CHANNEL_COUNT + CHANNEL_COUNT*(RAW_COUNT+FP_COUNT) + COARSE_W;
   localparam int NBYTES = (REC_W + 7) / 8;
   localparam int SW     = NBYTES * 8;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LW     = AW + 1;
   localparam int IW     = $clog2(NBYTES + 1);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, HEADER = 2'd2, PAYLOAD = 2'd3;
   logic [COARSE_W-1:0]      coarse;
   logic [CHANNEL_COUNT-1:0] q;
   logic [REC_W-1:0]         rec;
   logic [REC_W-1:0]         mem [FIFO_DEPTH];
   logic                     rec_vld;
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic [LW-1:0]            level;
   logic [SW-1:0]            sr;
   logic [IW-1:0]            idx;
   logic [1:0]               state;
   logic                     lost_flag, pop, full, wr, drop, last;
   assign q = detect_i & chan_en_i & (edge_sel_i == 2'b00 ? {CHANNEL_COUNT{1'b1}} :
                                      edge_sel_i == 2'b01 ? polarity_i :
                                      edge_sel_i == 2'b10 ? ~polarity_i : {CHANNEL_COUNT{1'b0}});
   assign pop  = state == LOAD;
   assign full = level == LW'(FIFO_DEPTH);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
   assign wr   = rec_vld & (~full | pop);
   assign drop = rec_vld & full & ~pop;
   assign last = idx == IW'(NBYTES - 1);
   assign omux_req_o   = state[1];
   assign omux_data_o  = state == HEADER ? {lost_flag, 7'h2A} : state == PAYLOAD ? sr[7:0] : 8'h00;
   assign fifo_level_o = level;
   always_ff @(posedge clk_i) if (wr) mem[wr_ptr] <= rec;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         coarse       <= '0;
         rec_vld      <= 1'b0;
         rec          <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         sr           <= '0;
         idx          <= '0;
         state        <= IDLE;
         lost_flag    <= 1'b0;
         lost_count_o <= '0;
      end else begin
         coarse  <= coarse + COARSE_W'(1);
         rec_vld <= |q;
         rec     <= {coarse, fp_i, raw_i, q, polarity_i & q};
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            sr     <= SW'(mem[rd_ptr]);
         end
         level <= level + LW'(wr) - LW'(pop);
         if (drop && lost_count_o != 16'hFFFF) lost_count_o <= lost_count_o + 16'd1;
         // a drop coinciding with header consumption keeps the flag set
         lost_flag <= drop | (lost_flag & ~(state == HEADER && omux_sel_i));
         if (state == IDLE && level != '0) state <= LOAD;
         if (state == LOAD) state <= HEADER;
         if (state == HEADER && omux_sel_i) begin
            state <= PAYLOAD;
            idx   <= '0;
         end
         if (state == PAYLOAD && omux_sel_i) begin
            sr  <= sr >> 8;
            idx <= idx + IW'(1);
            if (last) state <= level != '0 ? LOAD : IDLE;
         end
      end
   end
endmodule

// File: tb/tb_record_packer.sv
// tb_record_packer: scoreboard bench for record_packer (default build plus a COARSE_W=8, FIFO_DEPTH=2 build)
module tb_record_packer;
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   logic        reset_i, omux_sel_i, omux_req_o;
   logic [1:0]  detect_i, polarity_i, chan_en_i, edge_sel_i;
   logic [17:0] raw_i;
   logic [25:0] fp_i;
   logic [7:0]  omux_data_o;
   logic [15:0] lost_count_o;
   logic [4:0]  fifo_level_o;
   logic        reset2, sel2, req2;
   logic [1:0]  det2, pol2, en2, es2;
   logic [17:0] raw2;
   logic [25:0] fp2;
   logic [7:0]  data2;
   logic [15:0] lost2;
   logic [1:0]  level2;
   record_packer dut (
      .clk_i(clk_i), .reset_i(reset_i), .detect_i(detect_i), .polarity_i(polarity_i),
      .raw_i(raw_i), .fp_i(fp_i), .chan_en_i(chan_en_i), .edge_sel_i(edge_sel_i),
      .omux_req_o(omux_req_o), .omux_sel_i(omux_sel_i), .omux_data_o(omux_data_o),
      .lost_count_o(lost_count_o), .fifo_level_o(fifo_level_o));
   record_packer #(.COARSE_W(8), .FIFO_DEPTH(2)) dut2 (
      .clk_i(clk_i), .reset_i(reset2), .detect_i(det2), .polarity_i(pol2),
      .raw_i(raw2), .fp_i(fp2), .chan_en_i(en2), .edge_sel_i(es2),
      .omux_req_o(req2), .omux_sel_i(sel2), .omux_data_o(data2),
      .lost_count_o(lost2), .fifo_level_o(level2));
   int n_cmp = 0, n_bad = 0, taken = 0;
   logic [7:0]  exp_q[$], exp_q2[$];
   logic [31:0] mc;
   logic [7:0]  mc2;
   bit          rnd_sel = 0;
   always @(posedge clk_i) mc  <= reset_i ? 32'd0 : mc + 32'd1;
   always @(posedge clk_i) mc2 <= reset2 ? 8'd0 : mc2 + 8'd1;
   always @(posedge clk_i) if (rnd_sel) begin
      #1 omux_sel_i = 1'($urandom_range(0, 1));
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [47:0] body(input logic [1:0] det, pol, en, es, input logic [17:0] raw, input logic [25:0] fp);
      logic [1:0] qq;
      for (int i = 0; i < 2; i++) begin
         qq[i] = 1'b0;
         if (det[i] && en[i]) begin
            if (es == 2'b00) qq[i] = 1'b1;
            else if (es == 2'b01) qq[i] = pol[i];
            else if (es == 2'b10) qq[i] = ~pol[i];
         end
      end
      return {fp, raw, qq, pol & qq};
   endfunction
   task automatic push(input bit which, input logic [7:0] hdr, input logic [79:0] r, input int nb);
      if (which) exp_q2.push_back(hdr); else exp_q.push_back(hdr);
      for (int i = 0; i < nb; i++)
         if (which) exp_q2.push_back(r[8*i +: 8]); else exp_q.push_back(r[8*i +: 8]);
   endtask
   task automatic hit(input logic [1:0] det, pol, input logic [17:0] raw, input logic [25:0] fp, input logic [7:0] hdr, input bit store);
      logic [47:0] b;
      detect_i = det; polarity_i = pol; raw_i = raw; fp_i = fp;
      b = body(det, pol, chan_en_i, edge_sel_i, raw, fp);
      if (b[3:2] != 2'b00 && store) push(1'b0, hdr, {mc, b}, 10);
      @(posedge clk_i); #1;
      detect_i = 2'b00;
   endtask
   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || omux_req_o) && t < 3000) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask
   logic [7:0] prev_d, prev_d2;
   logic       prev_hold = 1'b0, prev_hold2 = 1'b0;
   always @(negedge clk_i) begin
      if (reset_i) prev_hold <= 1'b0;
      else begin
         if (omux_req_o && prev_hold)
            chk("hold", {prev_d[7] ? omux_data_o[7] : 1'b0, omux_data_o[6:0]}, {24'd0, prev_d});
         if (omux_req_o && omux_sel_i) begin
            taken++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL byte: got unexpected %0h expected none", omux_data_o);
            end else chk("byte", {24'd0, omux_data_o}, {24'd0, exp_q.pop_front()});
         end
         if (!omux_req_o) chk("idle_data", {24'd0, omux_data_o}, 32'd0);
         prev_hold <= omux_req_o && !omux_sel_i;
         prev_d    <= omux_data_o;
      end
   end
   always @(negedge clk_i) begin
      if (reset2) prev_hold2 <= 1'b0;
      else begin
         if (req2 && prev_hold2)
            chk("hold2", {prev_d2[7] ? data2[7] : 1'b0, data2[6:0]}, {24'd0, prev_d2});
         if (req2 && sel2) begin
            if (exp_q2.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL byte2: got unexpected %0h expected none", data2);
            end else chk("byte2", {24'd0, data2}, {24'd0, exp_q2.pop_front()});
         end
         if (!req2) chk("idle_data2", {24'd0, data2}, 32'd0);
         prev_hold2 <= req2 && !sel2;
         prev_d2    <= data2;
      end
   end
   initial begin
      #1_500_000;
      $display("FAIL watchdog: got no end expected finish");
      $fatal(1, "watchdog");
   end
   task automatic main_tests();
      int t, start;
      reset_i = 1'b1; omux_sel_i = 1'b0; detect_i = '0; polarity_i = '0;
      raw_i = '0; fp_i = '0; chan_en_i = 2'b11; edge_sel_i = 2'b00;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      chk("rst_req", {31'd0, omux_req_o}, 32'd0);
      chk("rst_data", {24'd0, omux_data_o}, 32'd0);
      chk("rst_level", {27'd0, fifo_level_o}, 32'd0);
      chk("rst_lost", {16'd0, lost_count_o}, 32'd0);
      omux_sel_i = 1'b1;
      hit(2'b01, 2'b01, {9'h000, 9'h155}, {13'h0000, 13'h0ABC}, 8'h2A, 1'b1);
      @(posedge clk_i); #1 chk("lat_n1", {31'd0, omux_req_o}, 32'd0);
      @(posedge clk_i); #1 chk("lat_n2", {31'd0, omux_req_o}, 32'd0);
      @(posedge clk_i); #1 chk("lat_n3", {31'd0, omux_req_o}, 32'd1);
      chk("hdr1", {24'd0, omux_data_o}, 32'h2A);
      wait_drain();
      chan_en_i = 2'b01;
      hit(2'b11, 2'b11, {9'h1AB, 9'h0CD}, {13'h1234, 13'h0567}, 8'h2A, 1'b1);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1 chk("masked_byte0", {24'd0, omux_data_o}, 32'hD5);
      wait_drain();
      chan_en_i = 2'b11; edge_sel_i = 2'b01;
      hit(2'b01, 2'b00, 18'h3FFFF, 26'h3FFFFFF, 8'h2A, 1'b1);
      repeat (4) @(posedge clk_i);
      #1 chk("no_rec_level", {27'd0, fifo_level_o}, 32'd0);
      chk("no_rec_req", {31'd0, omux_req_o}, 32'd0);
      edge_sel_i = 2'b00; omux_sel_i = 1'b0;
      hit(2'b01, 2'b01, 18'h00011, 26'h0000022, 8'hAA, 1'b1);
      t = 0;
      while (!omux_req_o && t < 10) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("stuck_req", {31'd0, omux_req_o}, 32'd1);
      for (int i = 0; i < 18; i++)
         hit(2'b10, 2'b10, 18'(i * 3 + 1), 26'(i * 77), 8'h2A, i < 16);
      repeat (3) @(posedge clk_i);
      #1 chk("full_level", {27'd0, fifo_level_o}, 32'd16);
      chk("full_lost", {16'd0, lost_count_o}, 32'd2);
      chk("full_hdr", {24'd0, omux_data_o}, 32'hAA);
      omux_sel_i = 1'b1;
      wait_drain();
      chk("lost_kept", {16'd0, lost_count_o}, 32'd2);
      rnd_sel = 1;
      for (int r = 0; r < 100; r++) begin
         t = 0;
         while (exp_q.size() > 66 && t < 5000) begin
            @(posedge clk_i); #1;
            t++;
         end
         hit(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 18'($urandom), 26'($urandom), 8'h2A, 1'b1);
      end
      rnd_sel = 0;
      @(posedge clk_i); #2 omux_sel_i = 1'b1;
      wait_drain();
      start = taken;
      for (int i = 0; i < 3; i++) hit(2'b11, 2'b01, 18'(i + 5), 26'(i + 9), 8'h2A, 1'b1);
      t = 0;
      while (taken < start + 5 && t < 100) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("pre_reset_taken", 32'(taken - start), 32'd5);
      reset_i = 1'b1;
      exp_q.delete();
      @(posedge clk_i); #1;
      chk("abort_req", {31'd0, omux_req_o}, 32'd0);
      chk("abort_data", {24'd0, omux_data_o}, 32'd0);
      chk("abort_level", {27'd0, fifo_level_o}, 32'd0);
      chk("abort_lost", {16'd0, lost_count_o}, 32'd0);
      reset_i = 1'b0;
      detect_i = 2'b01; polarity_i = 2'b01; raw_i = '0; fp_i = '0;
      push(1'b0, 8'h2A, {32'd0, 48'd0, 4'b0101} >> 0, 10);
      @(posedge clk_i); #1 detect_i = 2'b00;
      wait_drain();
   endtask
   task automatic small_tests();
      int t;
      reset2 = 1'b1; sel2 = 1'b1; det2 = '0; pol2 = '0; en2 = 2'b11; es2 = 2'b00; raw2 = '0; fp2 = '0;
      repeat (3) @(posedge clk_i);
      #1 reset2 = 1'b0;
      t = 0;
      while (mc2 != 8'hFF && t < 300) begin
         @(posedge clk_i); #1;
         t++;
      end
      det2 = 2'b01; pol2 = 2'b01; raw2 = 18'h00003; fp2 = 26'h0000004;
      push(1'b1, 8'h2A, {24'd0, 8'hFF, 26'h0000004, 18'h00003, 4'b0101}, 7);
      @(posedge clk_i); #1;
      det2 = 2'b10; pol2 = 2'b00; raw2 = 18'h00200; fp2 = 26'h0002000;
      push(1'b1, 8'h2A, {24'd0, 8'h00, 26'h0002000, 18'h00200, 4'b1000}, 7);
      @(posedge clk_i); #1 det2 = 2'b00;
      t = 0;
      while ((exp_q2.size() != 0 || req2) && t < 200) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("wrap_drain", 32'(exp_q2.size()), 32'd0);
      sel2 = 1'b0; det2 = 2'b01; pol2 = 2'b01;
      repeat (65600) @(posedge clk_i);
      #1 det2 = 2'b00;
      repeat (4) @(posedge clk_i);
      #1 chk("sat_lost", {16'd0, lost2}, 32'hFFFF);
      chk("sat_level", {30'd0, level2}, 32'd2);
      chk("sat_hdr", {24'd0, data2}, 32'hAA);
      det2 = 2'b01;
      @(posedge clk_i); #1 det2 = 2'b00;
      repeat (3) @(posedge clk_i);
      #1 chk("sat_hold", {16'd0, lost2}, 32'hFFFF);
   endtask
   initial begin
      fork
         main_tests();
         small_tests();
      join
      chk("final_q", 32'(exp_q.size() + exp_q2.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
